// File: rtl/lpc_pkg.sv
// Shared constants, state codes and lane types for the Levinson-Durbin
// recursion controller and its operand builder.
package lpc_pkg;

  localparam int MAX_ORDER = 10;
  localparam int LANES     = MAX_ORDER + 1;
  localparam int OPW       = 32;
  localparam int CW        = 16;

  localparam logic [OPW-1:0] Q15_ONE_32 = 32'd32768;
  localparam logic [CW-1:0]  K_UNSTABLE = 16'h8000;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t WAIT_K   = 3'd1;
  localparam state_t ISSUE    = 3'd2;
  localparam state_t WAIT_UPD = 3'd3;
  localparam state_t DONE     = 3'd4;

  // a[1..MAX_ORDER], element i-1 holds a[i]
  typedef logic [MAX_ORDER-1:0][CW-1:0] store_t;
  typedef logic [LANES-1:0][OPW-1:0]    opvec_t;
  typedef logic [LANES-1:0][CW-1:0]     resvec_t;

  function automatic logic [OPW-1:0] sext(input logic [CW-1:0] v);
    return {{(OPW-CW){v[CW-1]}}, v};
  endfunction

endpackage

// File: rtl/lpc_operand_mux.sv
// Builds the forward and reversed operand lanes for order m from the
// coefficient store; a[0] is the implicit Q15 1.0.
module lpc_operand_mux
  import lpc_pkg::*;
(
  input  store_t     a,
  input  logic [3:0] m,
  output opvec_t     op_fwd,
  output opvec_t     op_rev
);

  assign op_fwd[0] = Q15_ONE_32;

  for (genvar i = 1; i < LANES; i++) begin : g_fwd
    assign op_fwd[i] = (4'(i) < m) ? sext(a[i-1]) : '0;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_rev
    logic [3:0] j;
    assign j = m - 4'(i);
    // lane i carries a[m-i]; lanes beyond m stay zero
    assign op_rev[i] = (4'(i) > m)  ? '0 :
                       (j == 4'd0)  ? Q15_ONE_32 :
                                      sext(a[j - 4'd1]);
  end

endmodule

// File: rtl/lpc_recursion_ctrl.sv
// Levinson-Durbin order-recursion sequencer: accepts one k per order, drives
// the external coefficient-update datapath and writes its results back.
module lpc_recursion_ctrl
  import lpc_pkg::*;
#(
  parameter int ORDER   = MAX_ORDER,
  parameter int UPD_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [15:0]    k_in,
  input  logic           k_valid,
  output logic           k_ready,
  output logic [3:0]     order_m,
  output logic [351:0]   upd_aL,
  output logic [351:0]   upd_aR,
  output logic [15:0]    upd_k,
  output logic           upd_v,
  input  logic [175:0]   upd_a_next,
  output logic [159:0]   a_out,
  output logic           coeff_valid,
  output logic           done,
  output logic           err
);

  localparam int CNT_W = $clog2(UPD_LAT + 1);

  state_t           state;
  logic [3:0]       m;
  store_t           a_q;
  opvec_t           fwd_d, rev_d, fwd_q, rev_q;
  logic [CW-1:0]    k_q;
  logic             err_q, cv_q, done_q;
  logic [CNT_W-1:0] cnt;
  resvec_t          nxt;
  logic             unused_lane0;

  assign nxt          = upd_a_next;
  assign unused_lane0 = ^nxt[0];

  lpc_operand_mux u_mux (
    .a      (a_q),
    .m      (m),
    .op_fwd (fwd_d),
    .op_rev (rev_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      m      <= '0;
      a_q    <= '0;
      fwd_q  <= '0;
      rev_q  <= '0;
      k_q    <= '0;
      err_q  <= 1'b0;
      cv_q   <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= '0;
            m     <= 4'd1;
            err_q <= 1'b0;
            cv_q  <= 1'b0;
            state <= WAIT_K;
          end
        end
        WAIT_K: begin
          if (k_valid) begin
            k_q <= k_in;
            if (k_in == K_UNSTABLE) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              m      <= '0;
              state  <= IDLE;
            end else begin
              // operands frozen here and held until write-back
              fwd_q <= fwd_d;
              rev_q <= rev_d;
              cnt   <= '0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT_UPD;
        WAIT_UPD: begin
          // completion is timed purely by the latency counter
          if (cnt == CNT_W'(UPD_LAT - 1)) begin
            for (int i = 1; i <= MAX_ORDER; i++)
              if (4'(i) <= m) a_q[i-1] <= nxt[i];
            if (m == 4'(ORDER)) begin
              cv_q   <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              m     <= m + 4'd1;
              state <= WAIT_K;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          m     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign k_ready     = (state == WAIT_K);
  assign upd_v       = (state == ISSUE);
  assign order_m     = m;
  assign upd_aL      = fwd_q;
  assign upd_aR      = rev_q;
  assign upd_k       = k_q;
  assign a_out       = a_q;
  assign coeff_valid = cv_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lpc_recursion_ctrl.sv
// Bench: three controllers (ORDER 1, 2, 10) each driving a behavioural update
// datapath; final coefficients compared with a Levinson reference model.
module tb_lpc_recursion_ctrl;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0]         start, k_valid, k_ready, upd_v, coeff_valid, done, err;
  logic [N-1:0][15:0]   k_in, upd_k;
  logic [N-1:0][3:0]    order_m;
  logic [N-1:0][351:0]  upd_aL, upd_aR;
  logic [N-1:0][159:0]  a_out;

  int total = 0, passed = 0, nfail = 0;
  logic [15:0] kq [10];

  function automatic logic [175:0] dp(input logic [351:0] al, input logic [351:0] ar,
                                      input logic [15:0] k);
    logic [175:0] r;
    longint t;
    r = '0;
    for (int i = 0; i < 11; i++) begin
      t = (longint'($signed(al[32*i +: 32])) <<< 15)
        + longint'($signed(ar[32*i +: 32])) * longint'($signed(k)) + 64'sd16384;
      t = t >>> 15;
      r[16*i +: 16] = 16'(t);
    end
    return r;
  endfunction

  // Levinson order update a'[i] = a[i] + k*a[m-i] in Q15, round half up
  function automatic logic [159:0] golden(input int n);
    longint a [0:10];
    longint b [0:10];
    longint t;
    logic [159:0] r;
    for (int i = 0; i <= 10; i++) a[i] = 0;
    a[0] = 32768;
    for (int m = 1; m <= n; m++) begin
      if (kq[m-1] == 16'h8000) break;
      for (int i = 0; i <= 10; i++) b[i] = a[i];
      for (int i = 1; i <= m; i++) begin
        t = (b[i] * 32768 + b[m-i] * longint'($signed(kq[m-1])) + 16384) >>> 15;
        a[i] = longint'($signed(16'(t)));
      end
    end
    r = '0;
    for (int i = 1; i <= 10; i++) r[16*(i-1) +: 16] = 16'(a[i]);
    return r;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [175:0] nx, p0, p1;
    logic         v0, v1;

    lpc_recursion_ctrl #(.ORDER(g == 0 ? 1 : (g == 1 ? 2 : 10)), .UPD_LAT(3)) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .k_in(k_in[g]), .k_valid(k_valid[g]),
      .k_ready(k_ready[g]), .order_m(order_m[g]), .upd_aL(upd_aL[g]), .upd_aR(upd_aR[g]),
      .upd_k(upd_k[g]), .upd_v(upd_v[g]), .upd_a_next(nx), .a_out(a_out[g]),
      .coeff_valid(coeff_valid[g]), .done(done[g]), .err(err[g])
    );

    // result valid only in the 3rd cycle after upd_v; garbage otherwise
    always @(posedge clk) begin
      v0 <= upd_v[g];
      v1 <= v0;
      if (upd_v[g]) p0 <= dp(upd_aL[g], upd_aR[g], upd_k[g]);
      p1 <= p0;
      nx <= v1 ? p1 : 176'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    end
  end

  task automatic chkv(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin nfail++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin nfail++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end
  endtask

  task automatic check_zero(input int g, input string tag);
    chki({tag, "_flags"}, int'(|{k_ready[g], upd_v[g], coeff_valid[g], done[g], err[g]}), 0);
    chki({tag, "_order"}, int'(order_m[g]), 0);
    chkv({tag, "_a_out"}, a_out[g], '0);
    chki({tag, "_ops"}, int'(|{upd_aL[g], upd_aR[g], upd_k[g]}), 0);
  endtask

  task automatic rand_ks();
    for (int i = 0; i < 10; i++) begin
      kq[i] = 16'($urandom_range(0, 65535));
      if (kq[i] == 16'h8000) kq[i] = 16'h7FFF;
    end
  endtask

  // One recursion on DUT g with n k values from kq. hold: k_valid tied high.
  // rst_at: pulse rst at that cycle and stop. start_at: spurious start pulses.
  task automatic run(input int g, input int n, input int hold, input int rst_at, input int start_at);
    int c, idx, acc, nv, done_c, first_v, e, exp_done;
    logic acc_prev;
    logic [159:0] exp;
    c = 0; idx = 0; acc = 0; nv = 0; done_c = -1; first_v = -1; e = -1; acc_prev = 1'b0;
    for (int i = 0; i < n; i++) if (e < 0 && kq[i] == 16'h8000) e = i;
    exp = golden(n);
    @(negedge clk); start[g] = 1'b1;
    @(negedge clk); start[g] = 1'b0; c = 1;
    chki("start_clears_err", int'(err[g]), 0);
    chki("start_clears_cv", int'(coeff_valid[g]), 0);
    while (c < 400) begin
      if (acc_prev) idx++;
      if (start_at > 0) start[g] = (c >= start_at && c < start_at + 3);
      if (rst_at > 0 && c == rst_at) begin
        chki("pre_rst_order", int'(order_m[g]), 4);
        chki("pre_rst_busy", int'(k_ready[g]), 0);
        rst = 1'b1;
        @(negedge clk);
        check_zero(g, "mid_rst");
        rst = 1'b0; k_valid[g] = 1'b0;
        return;
      end
      if (upd_v[g]) begin nv++; if (first_v < 0) first_v = c; end
      if (done[g]) begin done_c = c; break; end
      k_in[g]    = (idx < n) ? kq[idx] : 16'($urandom());
      k_valid[g] = hold ? 1'b1 : (idx < n && $urandom_range(0, 2) != 0);
      acc_prev   = k_ready[g] && k_valid[g];
      if (acc_prev) begin
        acc++;
        chki("order_step", int'(order_m[g]), idx + 1);
      end
      @(negedge clk); c++;
    end
    k_valid[g] = 1'b0; start[g] = 1'b0;
    chki("done_seen", int'(done_c > 0), 1);
    if (hold) begin
      exp_done = (e >= 0) ? 2 + 5 * e : 5 * n + 1;
      chki("done_cycle", done_c, exp_done);
      chki("first_upd_v", first_v, (e == 0) ? -1 : 2);
    end
    chki("k_accepts", acc, (e >= 0) ? e + 1 : n);
    chki("upd_v_count", nv, (e >= 0) ? e : n);
    chki("err_flag", int'(err[g]), int'(e >= 0));
    chki("coeff_valid", int'(coeff_valid[g]), int'(e < 0));
    chkv("a_out", a_out[g], exp);
    @(negedge clk);
    chki("idle_order", int'(order_m[g]), 0);
    chki("idle_flags", int'({k_ready[g], done[g], upd_v[g]}), 0);
    chkv("a_out_hold", a_out[g], exp);
  endtask

  initial begin
    rst = 1'b1; start = '0; k_valid = '0; k_in = '0;
    for (int i = 0; i < 10; i++) kq[i] = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) check_zero(g, "reset");
    rst = 1'b0;

    kq[0] = 16'h4000; run(0, 1, 1, 0, 0);
    chki("t1_a1", int'(a_out[0][15:0]), 'h4000);

    kq[0] = 16'h4000; kq[1] = 16'h2000; run(1, 2, 1, 0, 0);
    chki("t2_a1", int'(a_out[1][15:0]), 'h5000);
    chki("t2_a2", int'(a_out[1][31:16]), 'h2000);

    kq[0] = 16'hC000; run(0, 1, 1, 0, 0);
    chki("t3_neg_round", int'(a_out[0][15:0]), 'hC000);
    rand_ks(); kq[0] = 16'hC000; run(2, 10, 1, 0, 0);
    repeat (2) begin rand_ks(); run(2, 10, 0, 0, 0); end

    rand_ks(); kq[2] = 16'h8000; run(2, 10, 1, 0, 0);
    rand_ks(); run(2, 10, 1, 0, 0);

    rand_ks(); run(2, 10, 1, 18, 0);
    rand_ks(); run(2, 10, 0, 0, 0);

    rand_ks(); run(2, 10, 1, 0, 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
